// File: rtl/cpu_controller.sv
// cpu_controller
//   Instruction register, decoder and control FSM for the 16-bit RISC
//   datapath. It latches one instruction in WAIT. A pulse on s_i starts
//   execution. It then sequences operand reads, ALU execute, status load
//   and register write-back, and returns to WAIT.
//
// Ports
//   clk_i                 rising-edge clock
//   reset_i               synchronous active-high reset
//   s_i                   start request (honoured only in WAIT)
//   load_ir_i             IR load enable (honoured only in WAIT)
//   in_i[15:0]            instruction word
//   w_o                   high while idle in WAIT
//   readnum_o/writenum_o  register select (always equal)
//   vsel_o[1:0]           write-back source: 00 ALU result, 10 sximm8
//   loada_o/loadb_o/loadc_o/loads_o/write_o   datapath enables
//   asel_o/bsel_o         ALU operand selects (bsel_o is held at 0)
//   shift_o, ALUop_o      IR[4:3], IR[12:11]
//   sximm8_o, sximm5_o    sign-extended immediates from IR
module cpu_controller (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        s_i,
    input  logic        load_ir_i,
    input  logic [15:0] in_i,
    output logic        w_o,
    output logic [2:0]  readnum_o,
    output logic [2:0]  writenum_o,
    output logic [1:0]  vsel_o,
    output logic        loada_o,
    output logic        loadb_o,
    output logic        loadc_o,
    output logic        loads_o,
    output logic        write_o,
    output logic        asel_o,
    output logic        bsel_o,
    output logic [1:0]  shift_o,
    output logic [1:0]  ALUop_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // Registered control outputs.
    logic       w_q, w_d;
    logic [2:0] rnum_q, rnum_d;
    logic [1:0] vsel_q, vsel_d;
    logic       loada_q, loada_d;
    logic       loadb_q, loadb_d;
    logic       loadc_q, loadc_d;
    logic       loads_q, loads_d;
    logic       write_q, write_d;
    logic       asel_q, asel_d;

    // Instruction fields of the IR value that will be in place after this
    // edge. Outputs are registered, so they are computed one cycle ahead
    // from the next state and the next IR. An IR load on the DECODE entry
    // edge is therefore already visible in DECODE.
    logic [2:0] opc_n, rn_n, rd_n, rm_n;
    logic [1:0] op_n;
    logic       is_movimm, is_movreg, is_alu, is_cmp;

    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load_ir_i) begin
            ir_d = in_i;
        end
    end

    assign opc_n = ir_d[15:13];
    assign op_n  = ir_d[12:11];
    assign rn_n  = ir_d[10:8];
    assign rd_n  = ir_d[7:5];
    assign rm_n  = ir_d[2:0];

    assign is_movimm = (opc_n == 3'b110) && (op_n == 2'b10);
    assign is_movreg = (opc_n == 3'b110) && (op_n == 2'b00);
    assign is_alu    = (opc_n == 3'b101);
    assign is_cmp    = is_alu && (op_n == 2'b01);

    // Next-state logic. Outside WAIT, ir_d equals ir_q, so decoding from
    // ir_d is the same as decoding from the held instruction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:      if (s_i) state_d = S_DECODE;
            S_DECODE: begin
                if (is_movimm)      state_d = S_WRITE_IMM;
                else if (is_movreg) state_d = S_GET_B;
                else if (is_alu)    state_d = S_GET_A;
                else                state_d = S_WAIT;   // undefined: no writes
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore outputs for the state being entered.
    always_comb begin
        w_d     = 1'b0;
        rnum_d  = rn_n;
        vsel_d  = 2'b00;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        write_d = 1'b0;
        asel_d  = 1'b0;
        case (state_d)
            S_WAIT:      w_d = 1'b1;
            S_WRITE_IMM: begin
                vsel_d  = 2'b10;
                write_d = 1'b1;
            end
            S_GET_A:     loada_d = 1'b1;
            S_GET_B: begin
                rnum_d  = rm_n;
                loadb_d = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes Rm through the ALU with A forced to zero.
                asel_d  = is_movreg;
                loads_d = is_cmp;
                loadc_d = ~is_cmp;
            end
            S_WRITE_REG: begin
                rnum_d  = rd_n;
                write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
            w_q     <= 1'b1;
            rnum_q  <= 3'd0;
            vsel_q  <= 2'b00;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            write_q <= 1'b0;
            asel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            w_q     <= w_d;
            rnum_q  <= rnum_d;
            vsel_q  <= vsel_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            write_q <= write_d;
            asel_q  <= asel_d;
        end
    end

    assign w_o        = w_q;
    assign readnum_o  = rnum_q;
    assign writenum_o = rnum_q;
    assign vsel_o     = vsel_q;
    assign loada_o    = loada_q;
    assign loadb_o    = loadb_q;
    assign loadc_o    = loadc_q;
    assign loads_o    = loads_q;
    assign write_o    = write_q;
    assign asel_o     = asel_q;
    assign bsel_o     = 1'b0;

    assign shift_o  = ir_q[4:3];
    assign ALUop_o  = ir_q[12:11];
    assign sximm8_o = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5_o = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and control state machine that drives the `datapath` block's control inputs for the simple 16-bit RISC machine. It latches one instruction and starts execution on a `s` pulse. It sequences register reads, ALU execute, status load and register write-back over 3-6 cycles, then raises `w` when idle. Its outputs connect directly to the matching `datapath` ports. The remaining `datapath` inputs (`PC`, `mdata`) are tied to zero at the top level.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `s`  in  1  start request; honoured only in WAIT.
- `load_ir`  in  1  instruction register load enable; honoured only in WAIT.
- `in`  in  16  instruction word.
- `w`  out  1  high in WAIT (idle, ready for `s`).
- `readnum`, `writenum`  out  3  register select (same value on both).
- `vsel`  out  2  write-back source: 00 ALU result, 10 `sximm8`.
- `loada`, `loadb`, `loadc`, `loads`, `write`  out  1  datapath enables.
- `asel`, `bsel`  out  1  ALU operand selects; `bsel` is held at 0.
- `shift`  out  2  equals IR[4:3].
- `ALUop`  out  2  equals IR[12:11].
- `sximm8`  out  16  IR[7:0] sign-extended.
- `sximm5`  out  16  IR[4:0] sign-extended.

## Operation
- **Instruction fields:** opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- **Supported instructions:**
  - MOV Rn,#imm8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD (101/00), CMP (101/01), AND (101/10), MVN (101/11).
- **IR:** 16-bit register. Loads `in` on a clock edge when `load_ir`=1 and the state is WAIT. In any other state `load_ir` is ignored, so an in-flight instruction is never disturbed. Reset value is 0x0000.
- **Combinational outputs:** `shift`, `ALUop`, `sximm8` and `sximm5` are driven from IR at all times.
- **Default outputs (every state unless overridden below):** `loada`, `loadb`, `loadc`, `loads` and `write` are 0. `asel`=0, `bsel`=0, `vsel`=00. `readnum`=`writenum`=Rn.
- **States and transitions:**
  - WAIT: `w`=1. If `s`=1, go to DECODE; otherwise stay.
  - DECODE: `w`=0, no enables. Next state by instruction: MOV imm -> WRITE_IMM; MOV reg -> GET_B; ADD, CMP, AND, MVN -> GET_A; any other opcode/op combination -> WAIT with no writes.
  - WRITE_IMM: select Rn, `vsel`=10, `write`=1. Next: WAIT.
  - GET_A: select Rn, `loada`=1. Next: GET_B.
  - GET_B: select Rm, `loadb`=1. Next: EXEC.
  - EXEC: `asel`=1 for MOV reg, otherwise 0.
    - For CMP: `loads`=1, `loadc`=0. Next: WAIT.
    - For all other instructions: `loadc`=1. Next: WRITE_REG.
  - WRITE_REG: select Rd, `vsel`=00, `write`=1. Next: WAIT.
- **Moore outputs:** all control outputs are decoded from the current state and IR only, never from `s` or `in`.

## Timing
- **Reset:** `reset`=1 forces state WAIT and IR=0 on the next edge, whatever the current state. Any in-progress instruction is abandoned and no further enable is asserted. Reset overrides `s` and `load_ir` in the same cycle.
- **Output values after reset:** `w`=1; all enables 0; `vsel`=00; `asel`=`bsel`=0; `readnum`=`writenum`=0; `shift`=`ALUop`=00; `sximm8`=`sximm5`=0.
- **Cycles, counted from the edge that samples `s`=1 to the edge that returns to WAIT:**
  - MOV imm: 3 cycles.
  - MOV reg: 5 cycles.
  - CMP: 5 cycles.
  - ADD, AND, MVN: 6 cycles.
  - Undefined instruction: 2 cycles.
- `w` drops in the cycle after `s` is sampled. It rises in the cycle after the final write or status-load cycle.
- The datapath commits a write on the same edge that leaves WRITE_IMM or WRITE_REG.
- `s` held high continuously restarts execution immediately on each return to WAIT, with no bubble beyond the WAIT cycle itself.
- `s` and `load_ir` both high in WAIT: the IR loads and DECODE begins on the same edge. DECODE then decodes the newly loaded word.

## Test plan
- **Reset:** hold `reset` for 2 cycles in mid-GET_A -> next cycle state WAIT, `w`=1, `loada`=0, IR=0x0000, `sximm8`=0x0000.
- **MOV imm:** load 0xD007 (MOV R0,#7), pulse `s`.
  - DECODE, then WRITE_IMM with `writenum`=0, `vsel`=10, `write`=1, `sximm8`=0x0007.
  - `w`=1 3 cycles after `s`.
  - Repeat with 0xD0F0 -> `sximm8`=0xFFF0.
- **ADD with shift:** load 0xA148 (ADD R2,R1,R0,LSL#1).
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1.
  - EXEC: `shift`=01, `ALUop`=00, `asel`=0, `loadc`=1.
  - WRITE_REG: `writenum`=2, `vsel`=00, `write`=1.
  - 6 cycles total.
- **CMP:** load 0xA900 (CMP R1,R0) -> EXEC has `loads`=1, `loadc`=0, `ALUop`=01. No `write` in any cycle. WAIT 5 cycles after `s`.
- **MOV reg:** load 0xC060 (MOV R3,R0) -> GET_A skipped. GET_B `readnum`=0; EXEC `asel`=1, `loadc`=1; WRITE_REG `writenum`=3.
- **Undefined instruction and protected IR:**
  - Load 0x0000 (undefined) -> WAIT 2 cycles after `s`, no enables asserted.
  - During an ADD, drive `load_ir`=1 with `in`=0xD0FF -> IR unchanged and the ADD sequence completes exactly.
